// File: rtl/stereo_arb_pkg.sv
// Shared types and default sizes for the stereo FIFO read arbiter.
package stereo_arb_pkg;

    localparam int unsigned DefDataWidth = 24;
    localparam int unsigned DefSkewLimit = 64;
    localparam int unsigned DefCntWidth  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StPop,
        StCapt,
        StOut,
        StDrop
    } arb_state_e;

endpackage

// File: rtl/stereo_skew_timer.sv
// Counts consecutive one-sided WAIT cycles; expire_o flags the cycle whose increment
// reaches SKEW_LIMIT-1, at which point the arbiter drops the unpaired word.
module stereo_skew_timer
    import stereo_arb_pkg::*;
#(
    parameter int unsigned SKEW_LIMIT = DefSkewLimit
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(SKEW_LIMIT + 1);
    localparam logic [CntW-1:0] Thresh = CntW'(SKEW_LIMIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc  = cnt_q + 1'b1;
    assign expire_o = inc_i && (cnt_inc >= Thresh);

    // Next count: expiry also restarts from zero since the arbiter leaves WAIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expire_o) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_inc;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stereo_fifo_rd_arbiter.sv
// Pops matched left/right words from two FIFOs and presents them as one stereo frame.
// A side that runs ahead for too long has its head word dropped (skew_err_o pulse).
// Optional: define STEREO_UNDERRUN_CNT_EN to add the saturating underrun_cnt_o counter.
module stereo_fifo_rd_arbiter
    import stereo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned FWFT       = 1,
    parameter int unsigned SKEW_LIMIT = DefSkewLimit,
    parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  l_empty_i,
    output logic                  l_rd_en_o,
    input  logic [DATA_WIDTH-1:0] l_rd_data_i,
    input  logic                  r_empty_i,
    output logic                  r_rd_en_o,
    input  logic [DATA_WIDTH-1:0] r_rd_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_left_o,
    output logic [DATA_WIDTH-1:0] out_right_o,
    output logic                  skew_err_o
`ifdef STEREO_UNDERRUN_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  underrun_cnt_o
`endif
);

    arb_state_e            state_q;
    logic                  l_rd_en_q, r_rd_en_q, out_valid_q, skew_err_q;
    logic [DATA_WIDTH-1:0] out_left_q, out_right_q;

    logic both_avail, one_sided, skew_expire;

    assign both_avail = !l_empty_i && !r_empty_i;
    assign one_sided  = (state_q == StWait) && en_i && (l_empty_i != r_empty_i);

    stereo_skew_timer #(
        .SKEW_LIMIT (SKEW_LIMIT)
    ) u_skew_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (!one_sided),
        .inc_i    (one_sided),
        .expire_o (skew_expire)
    );

    // Pairing FSM; every output is a register written alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            l_rd_en_q   <= 1'b0;
            r_rd_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
            skew_err_q  <= 1'b0;
        end else begin
            l_rd_en_q  <= 1'b0;
            r_rd_en_q  <= 1'b0;
            skew_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (en_i) state_q <= StWait;
                end
                StWait: begin
                    if (!en_i) begin
                        state_q <= StIdle;
                    end else if (both_avail) begin
                        state_q   <= StPop;
                        l_rd_en_q <= 1'b1;
                        r_rd_en_q <= 1'b1;
                    end else if (skew_expire) begin
                        // Only the non-empty side is read; the word is discarded.
                        state_q    <= StDrop;
                        l_rd_en_q  <= !l_empty_i;
                        r_rd_en_q  <= !r_empty_i;
                        skew_err_q <= 1'b1;
                    end
                end
                StPop: begin
                    if (FWFT != 0) begin
                        out_left_q  <= l_rd_data_i;
                        out_right_q <= r_rd_data_i;
                        out_valid_q <= 1'b1;
                        state_q     <= StOut;
                    end else begin
                        state_q <= StCapt;
                    end
                end
                StCapt: begin
                    out_left_q  <= l_rd_data_i;
                    out_right_q <= r_rd_data_i;
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    // A held frame is always delivered, even if en_i has fallen.
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (!en_i) begin
                            state_q <= StIdle;
                        end else if (both_avail) begin
                            state_q   <= StPop;
                            l_rd_en_q <= 1'b1;
                            r_rd_en_q <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StDrop: begin
                    state_q <= StWait;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign l_rd_en_o   = l_rd_en_q;
    assign r_rd_en_o   = r_rd_en_q;
    assign out_valid_o = out_valid_q;
    assign out_left_o  = out_left_q;
    assign out_right_o = out_right_q;
    assign skew_err_o  = skew_err_q;

`ifdef STEREO_UNDERRUN_CNT_EN
    logic [CNT_WIDTH-1:0] underrun_q;

    // Counts cycles the consumer is ready but starved by an empty FIFO; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= '0;
        end else if ((state_q == StWait) && en_i && out_ready_i && !out_valid_q &&
                     (l_empty_i || r_empty_i) && (underrun_q != '1)) begin
            underrun_q <= underrun_q + 1'b1;
        end
    end

    assign underrun_cnt_o = underrun_q;
`else
    logic unused_cnt_width;
    assign unused_cnt_width = (CNT_WIDTH != 0);
`endif

endmodule
